pico_io_hub: RTL and testbench

Parametrised port-mapped I/O peripheral for the KCPSM3 (PicoBlaze) port bus. It replaces single-register LED/switch glue with a set of features:
- N output registers with readback.
- N synchronised input channels with per-channel change detection.
- A write-1-to-clear status register and a maskable interrupt request with KCPSM3 acknowledge handling.

It sits between the processor's `port_id`/strobe bus and the board-level switches and LEDs.

---
 rtl/pico_io_pkg.sv | 22 ++
 rtl/pico_io_sync.sv | 41 ++++
 rtl/pico_io_hub.sv | 127 ++++++++++++
 tb/tb_pico_io_hub.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pico_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pico_io_pkg
// Description : Port-map offsets and arming-state encoding for pico_io_hub.
// Revision    : 1.0 - initial release
// ============================================================================
package pico_io_pkg;

    localparam logic [7:0] OFS_OUT    = 8'h00;
    localparam logic [7:0] OFS_IN     = 8'h10;
    localparam logic [7:0] OFS_STATUS = 8'h20;
    localparam logic [7:0] OFS_MASK   = 8'h21;
    localparam logic [7:0] OFS_ID     = 8'h22;

    typedef enum logic [1:0] {
        ARM0  = 2'd0,
        ARM1  = 2'd1,
        ARMED = 2'd2
    } arm_state_e;

endpackage
`default_nettype wire

// File: rtl/pico_io_sync.sv
`default_nettype none
// ============================================================================
// Module      : pico_io_sync
// Description : One input channel: 2-flop synchroniser, previous register and
//               an arm-gated change pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module pico_io_sync #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic [DATA_W-1:0] gpi,
    output logic [DATA_W-1:0] sync_val,
    output logic              changed
);

    logic [DATA_W-1:0] meta_q;
    logic [DATA_W-1:0] sync_q;
    logic [DATA_W-1:0] prev_q;

    // While disarmed, prev primes from the first stage so that it already
    // equals sync_q on the first armed cycle; fill never looks like a change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= gpi;
            sync_q <= meta_q;
            prev_q <= arm ? sync_q : meta_q;
        end
    end

    assign sync_val = sync_q;
    assign changed  = arm && (sync_q != prev_q);

endmodule
`default_nettype wire

// File: rtl/pico_io_hub.sv
`default_nettype none
// ============================================================================
// Module      : pico_io_hub
// Description : KCPSM3 port-mapped I/O hub: output registers, synchronised
//               inputs with change status, W1C status, mask and interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module pico_io_hub
    import pico_io_pkg::*;
#(
    parameter int               DATA_W    = 8,
    parameter int               N_OUT     = 4,
    parameter int               N_IN      = 4,
    parameter logic [7:0]       BASE_ADDR = 8'h00,
    parameter logic [DATA_W-1:0] OUT_RESET = '0,
    parameter logic [7:0]       HUB_ID    = 8'hA1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              port_id,
    input  logic                    write_strobe,
    input  logic                    read_strobe,
    input  logic [7:0]              out_port,
    output logic [7:0]              in_port,
    output logic                    interrupt,
    input  logic                    interrupt_ack,
    input  logic [N_IN*DATA_W-1:0]  gpi,
    output logic [N_OUT*DATA_W-1:0] gpo
);

    logic [7:0]        ofs;
    arm_state_e        arm_state_q;
    logic              armed_q;
    logic [DATA_W-1:0] out_q    [N_OUT];
    logic [DATA_W-1:0] out_d    [N_OUT];
    logic [DATA_W-1:0] sync_val [N_IN];
    logic [N_IN-1:0]   changed;
    logic [N_IN-1:0]   w1c;
    logic [N_IN-1:0]   status_q, status_d;
    logic [N_IN-1:0]   mask_q, mask_d;
    logic              irq_q, irq_d;
    logic [7:0]        rdata_d, in_port_q;

    // Port ids below the base wrap to large offsets and fall into unmapped space.
    assign ofs = port_id - BASE_ADDR;

    generate
        for (genvar i = 0; i < N_IN; i++) begin : g_chan
            pico_io_sync #(.DATA_W(DATA_W)) u_sync (
                .clk      (clk),
                .reset    (reset),
                .arm      (armed_q),
                .gpi      (gpi[i*DATA_W +: DATA_W]),
                .sync_val (sync_val[i]),
                .changed  (changed[i])
            );
        end
        for (genvar i = 0; i < N_OUT; i++) begin : g_gpo
            assign gpo[i*DATA_W +: DATA_W] = out_q[i];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arm_state_q <= ARM0;
            armed_q     <= 1'b0;
        end else begin
            case (arm_state_q)
                ARM0: arm_state_q <= ARM1;
                ARM1: begin
                    arm_state_q <= ARMED;
                    armed_q     <= 1'b1;
                end
                default: begin
                    arm_state_q <= ARMED;
                    armed_q     <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < N_OUT; i++) begin
            out_d[i] = (write_strobe && ofs == 8'(OFS_OUT + i)) ? out_port[DATA_W-1:0] : out_q[i];
        end
        w1c      = (write_strobe && ofs == OFS_STATUS) ? out_port[N_IN-1:0] : '0;
        // A change arriving with its own clear keeps the bit set.
        status_d = (status_q & ~w1c) | changed;
        mask_d   = (write_strobe && ofs == OFS_MASK) ? out_port[N_IN-1:0] : mask_q;
        irq_d    = (|(status_q & mask_q)) && !interrupt_ack;

        rdata_d = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (ofs == 8'(OFS_OUT + i)) rdata_d[DATA_W-1:0] = out_q[i];
        end
        for (int i = 0; i < N_IN; i++) begin
            if (ofs == 8'(OFS_IN + i)) rdata_d[DATA_W-1:0] = sync_val[i];
        end
        if (ofs == OFS_STATUS) rdata_d[N_IN-1:0] = status_q;
        if (ofs == OFS_MASK)   rdata_d[N_IN-1:0] = mask_q;
        if (ofs == OFS_ID)     rdata_d = HUB_ID;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_OUT; i++) out_q[i] <= OUT_RESET;
            status_q  <= '0;
            mask_q    <= '0;
            irq_q     <= 1'b0;
            in_port_q <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) out_q[i] <= out_d[i];
            status_q  <= status_d;
            mask_q    <= mask_d;
            irq_q     <= irq_d;
            in_port_q <= rdata_d;
        end
    end

    assign in_port   = in_port_q;
    assign interrupt = irq_q;

    a_no_rw_collision : assert property (@(posedge clk) disable iff (!reset)
        !(read_strobe && write_strobe));

endmodule
`default_nettype wire

// File: tb/tb_pico_io_hub.sv
`default_nettype none
// ============================================================================
// Module      : tb_pico_io_hub
// Description : Self-checking bench: vector table, directed corner sequences
//               and a randomized run against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pico_io_hub;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  port_id, out_port;
    logic        write_strobe, read_strobe, interrupt_ack;
    logic [31:0] gpi;
    logic [7:0]  in_port;
    logic        interrupt;
    logic [31:0] gpo;
    logic [7:0]  gpi4, in_port4, gpo4;
    logic        interrupt4;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    pico_io_hub #(.OUT_RESET(8'h3C)) u_dut (
        .clk(clk), .reset(reset), .port_id(port_id), .write_strobe(write_strobe),
        .read_strobe(read_strobe), .out_port(out_port), .in_port(in_port),
        .interrupt(interrupt), .interrupt_ack(interrupt_ack), .gpi(gpi), .gpo(gpo)
    );

    pico_io_hub #(.DATA_W(4), .N_OUT(2), .N_IN(2), .BASE_ADDR(8'h40),
                  .OUT_RESET(4'h9), .HUB_ID(8'h5C)) u_dut4 (
        .clk(clk), .reset(reset), .port_id(port_id), .write_strobe(write_strobe),
        .read_strobe(read_strobe), .out_port(out_port), .in_port(in_port4),
        .interrupt(interrupt4), .interrupt_ack(interrupt_ack), .gpi(gpi4), .gpo(gpo4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        read_strobe  = 1'b0;
        port_id      = p;
        out_port     = d;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
    endtask

    typedef struct {
        logic       we;
        logic [7:0] port;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[16];

    // Reference model state for the randomized run
    logic [7:0]  out_m [4];
    logic [3:0]  st_m, mk_m;
    logic [31:0] gh [4];   // gh[0] = gpi this cycle, gh[k] = k cycles earlier

    function automatic logic [7:0] mread(input logic [7:0] p);
        if (p < 8'h04)                   return out_m[p[1:0]];
        if (p >= 8'h10 && p < 8'h14)     return gh[2][int'(p[1:0])*8 +: 8];
        if (p == 8'h20)                  return {4'h0, st_m};
        if (p == 8'h21)                  return {4'h0, mk_m};
        if (p == 8'h22)                  return 8'hA1;
        return 8'h00;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] plist [14];
        logic [7:0] p, wd, exp_rd;
        logic       we, ack, irq_n;
        logic [3:0] chg, st_n, mk_n, w1c;
        logic [7:0] out_n [4];
        logic [31:0] ng;

        plist = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11, 8'h12,
                  8'h13, 8'h14, 8'h20, 8'h21, 8'h22, 8'h2F};
        vecs = '{
            '{1'b1, 8'h02, 8'h5A, 8'h5A}, '{1'b0, 8'h00, 8'h00, 8'h3C},
            '{1'b0, 8'h01, 8'h00, 8'h3C}, '{1'b0, 8'h03, 8'h00, 8'h3C},
            '{1'b0, 8'h22, 8'h00, 8'hA1}, '{1'b0, 8'h2F, 8'h00, 8'h00},
            '{1'b0, 8'h04, 8'h00, 8'h00}, '{1'b1, 8'h21, 8'hFF, 8'h0F},
            '{1'b1, 8'h21, 8'h00, 8'h00}, '{1'b0, 8'h14, 8'h00, 8'h00},
            '{1'b0, 8'h10, 8'h00, 8'hFF}, '{1'b1, 8'h23, 8'h77, 8'h00},
            '{1'b1, 8'h00, 8'hC3, 8'hC3}, '{1'b1, 8'h10, 8'h55, 8'hFF},
            '{1'b1, 8'h22, 8'h00, 8'hA1}, '{1'b0, 8'h20, 8'h00, 8'h00}
        };

        // ---------------- reset with inputs high ----------------
        reset = 1'b0; gpi = '1; gpi4 = '1; port_id = 8'h10; out_port = 8'h00;
        write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;
        ticks(2);
        chk("reset in_port", in_port, 8'h00);
        chk("reset interrupt", interrupt, 1'b0);
        chk("reset gpo", gpo, 32'h3C3C3C3C);
        chk("reset gpo4", gpo4, 8'h99);
        reset = 1'b1;
        ticks(3);
        chk("IN0 after fill", in_port, 8'hFF);
        port_id = 8'h20;
        ticks(6);
        chk("no spurious status", in_port, 8'h00);
        chk("no spurious irq", interrupt, 1'b0);

        // ---------------- register table ----------------
        for (int k = 0; k < 16; k++) begin
            port_id = vecs[k].port; out_port = vecs[k].wdata;
            write_strobe = vecs[k].we; read_strobe = !vecs[k].we;
            tick();
            write_strobe = 1'b0; read_strobe = 1'b1;
            tick();
            chk($sformatf("vec%0d port %02h", k, vecs[k].port), in_port, vecs[k].exp);
        end
        read_strobe = 1'b0;
        chk("gpo after table", gpo, 32'h3C5A3CC3);

        // ---------------- change, interrupt, ack, W1C ----------------
        gpi = '0;
        ticks(5);
        wr(8'h20, 8'h0F);
        wr(8'h21, 8'h01);
        gpi[7:0] = 8'h03; port_id = 8'h20;
        ticks(3);
        chk("irq not before status", interrupt, 1'b0);
        tick();
        chk("status ch0 set", in_port, 8'h01);
        chk("irq asserted", interrupt, 1'b1);
        interrupt_ack = 1'b1;
        tick();
        chk("irq dropped on ack", interrupt, 1'b0);
        interrupt_ack = 1'b0;
        tick();
        chk("irq reasserts", interrupt, 1'b1);
        wr(8'h20, 8'h01);
        tick();
        chk("irq off after W1C", interrupt, 1'b0);
        chk("status cleared", in_port, 8'h00);
        tick();
        chk("irq stays off", interrupt, 1'b0);

        // mask enabling an already-set bit
        wr(8'h21, 8'h00);
        gpi[7:0] = 8'h00; port_id = 8'h20;
        ticks(5);
        chk("masked irq off", interrupt, 1'b0);
        chk("masked status set", in_port, 8'h01);
        wr(8'h21, 8'h01);
        chk("irq not on mask edge", interrupt, 1'b0);
        tick();
        chk("irq after mask write", interrupt, 1'b1);

        // ack with nothing pending
        wr(8'h20, 8'h01);
        tick();
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        tick();
        chk("idle ack irq", interrupt, 1'b0);
        chk("idle ack status", in_port, 8'h00);

        // ---------------- W1C colliding with a new change ----------------
        gpi[15:8] = 8'h01; port_id = 8'h20;
        ticks(5);
        chk("status ch1 set", in_port, 8'h02);
        gpi[15:8] = 8'h00;
        ticks(2);
        wr(8'h20, 8'h02);
        tick();
        chk("W1C vs change set wins", in_port, 8'h02);
        wr(8'h20, 8'h02);
        tick();
        chk("W1C clears ch1", in_port, 8'h00);

        // ---------------- narrow instance ----------------
        wr(8'h40, 8'hFF);
        tick();
        chk("dw4 readback", in_port4, 8'h0F);
        chk("dw4 gpo", gpo4, 8'h9F);
        port_id = 8'h62;
        tick();
        chk("dw4 id", in_port4, 8'h5C);
        port_id = 8'h6F;
        tick();
        chk("dw4 unmapped", in_port4, 8'h00);

        // ---------------- asynchronous reset mid-operation ----------------
        gpi[7:0] = 8'h05;
        ticks(5);
        chk("pre-reset irq", interrupt, 1'b1);
        wr(8'h01, 8'h77);
        port_id = 8'h22;
        tick();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async irq", interrupt, 1'b0);
        chk("async in_port", in_port, 8'h00);
        chk("async gpo", gpo, 32'h3C3C3C3C);
        chk("async gpo4", gpo4, 8'h99);
        gpi = $urandom;
        ticks(3);
        reset = 1'b1;
        port_id = 8'h20;
        ticks(6);
        chk("post-reset status", in_port, 8'h00);

        // ---------------- randomized run against model ----------------
        for (int i = 0; i < 4; i++) begin
            out_m[i] = 8'h3C;
            gh[i]    = gpi;
        end
        st_m = '0; mk_m = '0;
        for (int c = 0; c < 300; c++) begin
            p   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : plist[$urandom_range(0, 13)];
            we  = ($urandom_range(0, 2) == 0);
            wd  = 8'($urandom);
            ack = ($urandom_range(0, 4) == 0);
            ng  = gh[0];
            if ($urandom_range(0, 3) == 0) ng[$urandom_range(0, 31)] ^= 1'b1;
            gh[3] = gh[2]; gh[2] = gh[1]; gh[1] = gh[0]; gh[0] = ng;
            port_id = p; out_port = wd; write_strobe = we; read_strobe = !we;
            interrupt_ack = ack; gpi = ng;

            exp_rd = mread(p);
            for (int ch = 0; ch < 4; ch++) chg[ch] = (gh[2][ch*8 +: 8] != gh[3][ch*8 +: 8]);
            irq_n = (|(st_m & mk_m)) && !ack;
            w1c   = (we && p == 8'h20) ? wd[3:0] : 4'h0;
            st_n  = (st_m & ~w1c) | chg;
            mk_n  = (we && p == 8'h21) ? wd[3:0] : mk_m;
            for (int i = 0; i < 4; i++) out_n[i] = (we && p == 8'(i)) ? wd : out_m[i];

            tick();
            chk($sformatf("rand%0d in_port p=%02h", c, p), in_port, exp_rd);
            chk($sformatf("rand%0d interrupt", c), interrupt, irq_n);
            chk($sformatf("rand%0d gpo", c), gpo, {out_n[3], out_n[2], out_n[1], out_n[0]});
            st_m = st_n; mk_m = mk_n;
            for (int i = 0; i < 4; i++) out_m[i] = out_n[i];
        end
        write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
